// File: rtl/speriph_port_scheduler_pkg.sv
// Shared constants and helpers for the cluster peripheral port scheduler.
package pulp_cluster_package;

    // Default depth of the issued-but-unanswered window on a peripheral slave port.
    localparam int unsigned SPER_MAX_OUTSTANDING = 32'd4;

    // Width of an index able to address n items; a single item still needs one bit.
    function automatic int unsigned sper_idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/speriph_port_scheduler_idx_fifo.sv
// In-order FIFO of requester indices for requests that are in flight on the slave port.
module speriph_idx_fifo
    import pulp_cluster_package::*;
#(
    parameter int unsigned Depth = SPER_MAX_OUTSTANDING,
    parameter int unsigned Width = 32'd2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned PtrWidth   = sper_idx_width(Depth);
    localparam int unsigned UsageWidth = $clog2(Depth + 32'd1);

    typedef logic [PtrWidth-1:0]   ptr_t;
    typedef logic [UsageWidth-1:0] usage_t;

    logic [Width-1:0] mem_q [Depth];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    usage_t           usage_q,  usage_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (usage_q == usage_t'(Depth));
    assign empty_o   = (usage_q == usage_t'(0));
    assign usage_o   = usage_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer advance with wrap at Depth, and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (push_ok_s) begin
            if (wr_ptr_q == ptr_t'(Depth - 32'd1)) begin
                wr_ptr_d = ptr_t'(0);
            end else begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            if (rd_ptr_q == ptr_t'(Depth - 32'd1)) begin
                rd_ptr_d = ptr_t'(0);
            end else begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   usage_d = usage_q + usage_t'(1);
            2'b01:   usage_d = usage_q - usage_t'(1);
            default: usage_d = usage_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every tracked entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= ptr_t'(0);
            rd_ptr_q <= ptr_t'(0);
            usage_q  <= usage_t'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: rtl/speriph_port_scheduler.sv
// Shares one peripheral slave port among NumIn requesters: round-robin arbitration with
// lock-in while a request waits for grant, in-order tracking of issued requests, and
// zero-latency routing of each response back to the requester that issued it.
module speriph_port_scheduler
    import pulp_cluster_package::*;
#(
    parameter int unsigned NumIn          = 32'd4,
    parameter int unsigned ReqWidth       = 32'd72,
    parameter int unsigned DataWidth      = 32'd32,
    parameter int unsigned MaxOutstanding = SPER_MAX_OUTSTANDING
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumIn-1:0]                      in_req_i,
    output logic [NumIn-1:0]                      in_gnt_o,
    input  logic [NumIn*ReqWidth-1:0]             in_wdata_i,
    output logic [NumIn-1:0]                      in_rvalid_o,
    output logic [DataWidth-1:0]                  in_rdata_o,
    output logic                                  in_ropc_o,
    output logic                                  out_req_o,
    input  logic                                  out_gnt_i,
    output logic [ReqWidth-1:0]                   out_wdata_o,
    input  logic                                  out_rvalid_i,
    input  logic [DataWidth-1:0]                  out_rdata_i,
    input  logic                                  out_ropc_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
    output logic                                  err_unexp_o
);

    localparam int unsigned IdxWidth = sper_idx_width(NumIn);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 32'd1);

    typedef logic [IdxWidth-1:0] idx_t;

    // Arbiter state
    idx_t                rr_ptr_q,   rr_ptr_d;
    logic                lock_q,     lock_d;
    idx_t                lock_idx_q, lock_idx_d;
    logic                err_unexp_q, err_unexp_d;

    // Arbitration
    idx_t                cand_s;
    idx_t                rr_sel_s;
    logic                rr_found_s;
    idx_t                sel_s;
    logic                out_req_s;
    logic                hs_s;
    logic [ReqWidth-1:0] wdata_arr_s [NumIn];

    // Response tracking
    idx_t                head_idx_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CntWidth-1:0] fifo_usage_s;
    logic                pop_s;
    logic                unexp_s;

    // Split the flat payload bus into one slot per requester.
    for (genvar g = 0; g < NumIn; g++) begin : g_wdata
        assign wdata_arr_s[g] = in_wdata_i[g*ReqWidth +: ReqWidth];
    end

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        rr_sel_s   = rr_ptr_q;
        rr_found_s = 1'b0;
        cand_s     = rr_ptr_q;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (!rr_found_s && in_req_i[cand_s]) begin
                rr_sel_s   = cand_s;
                rr_found_s = 1'b1;
            end else begin
                rr_found_s = rr_found_s;
            end
            if (cand_s == idx_t'(NumIn - 32'd1)) begin
                cand_s = idx_t'(0);
            end else begin
                cand_s = cand_s + idx_t'(1);
            end
        end
    end

    // A pending locked request keeps the port; a dropped one falls back to round-robin.
    always_comb begin
        if (lock_q && in_req_i[lock_idx_q]) begin
            sel_s = lock_idx_q;
        end else begin
            sel_s = rr_sel_s;
        end
    end

    // Full window blocks issue purely on the registered count, never on out_rvalid_i.
    assign out_req_s   = rst_ni & (|in_req_i) & ~fifo_full_s;
    assign hs_s        = out_req_s & out_gnt_i;
    assign out_req_o   = out_req_s;
    assign out_wdata_o = wdata_arr_s[sel_s];

    // Grant goes only to the selected requester, and only on a completed handshake.
    always_comb begin
        in_gnt_o = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            in_gnt_o[i] = hs_s && (sel_s == idx_t'(i));
        end
    end

    // A response pops the oldest issuer; one with nothing tracked is flagged instead.
    assign pop_s      = rst_ni & out_rvalid_i & ~fifo_empty_s;
    assign unexp_s    = out_rvalid_i & fifo_empty_s;
    assign in_rdata_o = out_rdata_i;
    assign in_ropc_o  = out_ropc_i;

    // Route the response valid to the requester at the head of the issue-order FIFO.
    always_comb begin
        in_rvalid_o = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            in_rvalid_o[i] = pop_s && (head_idx_s == idx_t'(i));
        end
    end

    speriph_idx_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs_s),
        .data_i  (sel_s),
        .pop_i   (pop_s),
        .data_o  (head_idx_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .usage_o (fifo_usage_s)
    );

    assign outstanding_o = fifo_usage_s;
    assign err_unexp_o   = err_unexp_q;

    // Next pointer/lock state: advance past the winner on handshake, lock while stalled.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = out_req_s & ~out_gnt_i;
        lock_idx_d  = lock_idx_q;
        err_unexp_d = err_unexp_q | unexp_s;
        if (hs_s) begin
            if (sel_s == idx_t'(NumIn - 32'd1)) begin
                rr_ptr_d = idx_t'(0);
            end else begin
                rr_ptr_d = sel_s + idx_t'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (lock_d) begin
            lock_idx_d = sel_s;
        end else begin
            lock_idx_d = lock_idx_q;
        end
    end

    // Arbiter and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= idx_t'(0);
            lock_q      <= 1'b0;
            lock_idx_q  <= idx_t'(0);
            err_unexp_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            err_unexp_q <= err_unexp_d;
        end
    end

endmodule

// File: tb/tb_speriph_port_scheduler.sv
// Directed bench for speriph_port_scheduler; responses are checked by a scoreboard monitor.
module tb_speriph_port_scheduler;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [3:0]   in_req_i;
    logic [3:0]   in_gnt_o;
    logic [287:0] in_wdata_i;
    logic [3:0]   in_rvalid_o;
    logic [31:0]  in_rdata_o;
    logic         in_ropc_o;
    logic         out_req_o;
    logic         out_gnt_i;
    logic [71:0]  out_wdata_o;
    logic         out_rvalid_i;
    logic [31:0]  out_rdata_i;
    logic         out_ropc_i;
    logic [2:0]   outstanding_o;
    logic         err_unexp_o;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        ropc;
    } rsp_t;

    rsp_t exp_q[$];
    logic rsp_due = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    speriph_port_scheduler #(
        .NumIn(4), .ReqWidth(72), .DataWidth(32), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_wdata_i(in_wdata_i),
        .in_rvalid_o(in_rvalid_o), .in_rdata_o(in_rdata_o), .in_ropc_o(in_ropc_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_wdata_o(out_wdata_o),
        .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i), .out_ropc_i(out_ropc_i),
        .outstanding_o(outstanding_o), .err_unexp_o(err_unexp_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [71:0] payload(input int k);
        return {8'hA0 + 8'(k), 32'hCAFE_0000 + 32'(k), 32'h1234_5600 + 32'(k)};
    endfunction

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] r;
        r = 4'b0000;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented or due response is matched against the queue head.
    always @(negedge clk_i) begin
        if (rsp_due || (in_rvalid_o !== 4'b0000)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: in_rvalid_o=%b expected none", in_rvalid_o);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rvalid", 72'(in_rvalid_o), 72'(onehot(int'(e.idx))));
                chk("rsp_rdata", 72'(in_rdata_o), 72'(e.data));
                chk("rsp_ropc", 72'(in_ropc_o), 72'(e.ropc));
            end
        end
    end

    task automatic set_in(input logic [3:0] req, input logic gnt, input logic rv,
                          input logic [31:0] rd, input logic ro,
                          input logic expect_rsp, input logic [1:0] eidx);
        rsp_t t;
        @(posedge clk_i);
        #1;
        in_req_i     = req;
        out_gnt_i    = gnt;
        out_rvalid_i = rv;
        out_rdata_i  = rd;
        out_ropc_i   = ro;
        rsp_due      = expect_rsp;
        if (expect_rsp) begin
            t.idx  = eidx;
            t.data = rd;
            t.ropc = ro;
            exp_q.push_back(t);
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        set_in(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_wdata_i[k*72 +: 72] = payload(k);
        end
        rst_ni       = 1'b0;
        in_req_i     = 4'hF;
        out_gnt_i    = 1'b1;
        out_rvalid_i = 1'b0;
        out_rdata_i  = 32'h0;
        out_ropc_i   = 1'b0;

        // Reset state, with requests present to show they are ignored
        @(negedge clk_i);
        chk("reset_out_req", 72'(out_req_o), 72'd0);
        chk("reset_gnt", 72'(in_gnt_o), 72'd0);
        chk("reset_rvalid", 72'(in_rvalid_o), 72'd0);
        chk("reset_outstanding", 72'(outstanding_o), 72'd0);
        chk("reset_err", 72'(err_unexp_o), 72'd0);
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        in_req_i = 4'b0000;
        out_gnt_i = 1'b0;

        // 1: all requesting, grant always, responses two cycles after issue
        for (int c = 0; c < 7; c++) begin
            set_in((c < 5) ? 4'hF : 4'h0, 1'b1, (c >= 2), 32'hD000_0000 + 32'(c),
                   1'(c & 1), (c >= 2), 2'((c + 2) % 4));
            chk("t1_outstanding", 72'(outstanding_o),
                72'(((c < 5) ? c : 5) - ((c > 2) ? c - 2 : 0)));
            if (c < 5) begin
                chk("t1_gnt", 72'(in_gnt_o), 72'(onehot(c % 4)));
                chk("t1_wdata", out_wdata_o, payload(c % 4));
            end
        end
        idle();
        chk("t1_outstanding_end", 72'(outstanding_o), 72'd0);

        // 2: lock-in on requester 0 while requester 2 appears (rr pointer is 1 here)
        set_in(4'b0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t2_out_req", 72'(out_req_o), 72'd1);
        chk("t2_gnt_wait0", 72'(in_gnt_o), 72'd0);
        chk("t2_wdata0", out_wdata_o, payload(0));
        for (int c = 0; c < 2; c++) begin
            set_in(4'b0101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
            chk("t2_gnt_wait", 72'(in_gnt_o), 72'd0);
            chk("t2_wdata_locked", out_wdata_o, payload(0));
        end
        set_in(4'b0101, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t2_gnt0", 72'(in_gnt_o), 72'(4'b0001));
        chk("t2_wdata_gnt0", out_wdata_o, payload(0));
        set_in(4'b0100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t2_gnt2", 72'(in_gnt_o), 72'(4'b0100));
        chk("t2_wdata_gnt2", out_wdata_o, payload(2));
        set_in(4'b0000, 1'b0, 1'b1, 32'hE000_0000, 1'b1, 1'b1, 2'd0);
        set_in(4'b0000, 1'b0, 1'b1, 32'hE000_0002, 1'b0, 1'b1, 2'd2);
        idle();
        chk("t2_outstanding_end", 72'(outstanding_o), 72'd0);

        // 3: window fills at 4 with no responses (rr pointer is 3 here)
        for (int b = 0; b < 4; b++) begin
            set_in(4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
            chk("t3_gnt", 72'(in_gnt_o), 72'(onehot((3 + b) % 4)));
            chk("t3_outstanding", 72'(outstanding_o), 72'(b));
        end
        for (int b = 0; b < 2; b++) begin
            set_in(4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
            chk("t3_full_out_req", 72'(out_req_o), 72'd0);
            chk("t3_full_gnt", 72'(in_gnt_o), 72'd0);
            chk("t3_full_outstanding", 72'(outstanding_o), 72'd4);
        end
        set_in(4'hF, 1'b1, 1'b1, 32'hF000_0003, 1'b0, 1'b1, 2'd3);
        chk("t3_rsp_cycle_out_req", 72'(out_req_o), 72'd0);
        chk("t3_rsp_cycle_gnt", 72'(in_gnt_o), 72'd0);
        set_in(4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t3_resume_out_req", 72'(out_req_o), 72'd1);
        chk("t3_resume_gnt", 72'(in_gnt_o), 72'(4'b1000));
        chk("t3_resume_outstanding", 72'(outstanding_o), 72'd3);
        set_in(4'b0000, 1'b0, 1'b1, 32'hF000_0010, 1'b0, 1'b1, 2'd0);
        set_in(4'b0000, 1'b0, 1'b1, 32'hF000_0011, 1'b1, 1'b1, 2'd1);
        idle();
        chk("t3_outstanding_left", 72'(outstanding_o), 72'd2);

        // 4: grant and response in the same cycle at count 2 (rr pointer is 0 here)
        set_in(4'b0010, 1'b1, 1'b1, 32'h4444_0002, 1'b0, 1'b1, 2'd2);
        chk("t4_gnt", 72'(in_gnt_o), 72'(4'b0010));
        chk("t4_outstanding_pre", 72'(outstanding_o), 72'd2);
        idle();
        chk("t4_outstanding_post", 72'(outstanding_o), 72'd2);
        set_in(4'b0000, 1'b0, 1'b1, 32'h4444_0003, 1'b1, 1'b1, 2'd3);
        set_in(4'b0000, 1'b0, 1'b1, 32'h4444_0001, 1'b0, 1'b1, 2'd1);
        idle();
        chk("t4_outstanding_end", 72'(outstanding_o), 72'd0);
        chk("t4_err_clear", 72'(err_unexp_o), 72'd0);

        // 5: response with nothing in flight
        set_in(4'b0000, 1'b0, 1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 2'd0);
        chk("t5_no_rvalid", 72'(in_rvalid_o), 72'd0);
        idle();
        chk("t5_err_set", 72'(err_unexp_o), 72'd1);
        idle();
        idle();
        chk("t5_err_sticky", 72'(err_unexp_o), 72'd1);

        // 6: reset with three requests in flight (rr pointer is 2 here)
        for (int c = 0; c < 3; c++) begin
            set_in(4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
            chk("t6_gnt", 72'(in_gnt_o), 72'(onehot((2 + c) % 4)));
        end
        idle();
        chk("t6_outstanding_pre", 72'(outstanding_o), 72'd3);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b0;
        in_req_i  = 4'hF;
        out_gnt_i = 1'b1;
        #1;
        chk("t6_rst_out_req", 72'(out_req_o), 72'd0);
        chk("t6_rst_gnt", 72'(in_gnt_o), 72'd0);
        chk("t6_rst_outstanding", 72'(outstanding_o), 72'd0);
        chk("t6_rst_err", 72'(err_unexp_o), 72'd0);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        in_req_i  = 4'b0000;
        out_gnt_i = 1'b0;
        set_in(4'b0000, 1'b0, 1'b1, 32'h5555_0000, 1'b0, 1'b0, 2'd0);
        chk("t6_stale_no_rvalid", 72'(in_rvalid_o), 72'd0);
        idle();
        chk("t6_stale_err", 72'(err_unexp_o), 72'd1);
        set_in(4'hF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
        chk("t6_rr_restart", 72'(in_gnt_o), 72'(4'b0001));
        set_in(4'b0000, 1'b0, 1'b1, 32'h6666_0000, 1'b1, 1'b1, 2'd0);
        idle();
        chk("t6_outstanding_end", 72'(outstanding_o), 72'd0);
        chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
